// File: rtl/full_adder_2bit.sv
// Two-stage ripple-carry adder: {Carry,Sum} = A + B + Cin, purely combinational.
// Define FA2_REG_OUT_EN to add the enabled, async-reset Sum_q/Carry_q output registers.
module full_adder_2bit (
    output logic [1:0] Sum,
    output logic       Carry,
    input  logic [1:0] A,
    input  logic [1:0] B,
    input  logic       Cin,
    input  logic       clk,
    input  logic       rst_n,
`ifdef FA2_REG_OUT_EN
    input  logic       en,
    output logic [1:0] Sum_q,
    output logic       Carry_q
`else
    input  logic       en
`endif
);

    logic w_s0;
    logic w_c0;
    logic w_s1;
    logic w_c1;

    // Bit 0 consumes Cin; bit 1 consumes the bit-0 carry. Plain gates, so X propagates.
    assign w_s0 = A[0] ^ B[0] ^ Cin;
    assign w_c0 = (A[0] & B[0]) | (A[0] & Cin) | (B[0] & Cin);
    assign w_s1 = A[1] ^ B[1] ^ w_c0;
    assign w_c1 = (A[1] & B[1]) | (A[1] & w_c0) | (B[1] & w_c0);

    assign Sum   = {w_s1, w_s0};
    assign Carry = w_c1;

`ifdef FA2_REG_OUT_EN
    logic [1:0] r_sum;
    logic       r_carry;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum   <= 2'b00;
            r_carry <= 1'b0;
        end else if (en) begin
            r_sum   <= {w_s1, w_s0};
            r_carry <= w_c1;
        end
    end

    assign Sum_q   = r_sum;
    assign Carry_q = r_carry;
`else
    // Clock, reset and enable stay on the port list so both builds share one pinout.
    logic w_unused;
    assign w_unused = &{1'b0, clk, rst_n, en};
`endif

endmodule

// File: tb/tb_full_adder_2bit.sv
// Self-checking bench for full_adder_2bit: directed table, exhaustive sweep, random
// vectors, and (with FA2_REG_OUT_EN) register load/hold/async-reset sequences.
module tb_full_adder_2bit;

    logic [1:0] A;
    logic [1:0] B;
    logic       Cin;
    logic       clk;
    logic       rst_n;
    logic       en;
    logic [1:0] Sum;
    logic       Carry;
`ifdef FA2_REG_OUT_EN
    logic [1:0] Sum_q;
    logic       Carry_q;
`endif

    int checks;
    int failures;

    typedef struct {
        logic [1:0] a;
        logic [1:0] b;
        logic       cin;
        logic [2:0] exp;
    } vec_t;

    vec_t vecs[8];

    full_adder_2bit dut (
        .Sum     (Sum),
        .Carry   (Carry),
        .A       (A),
        .B       (B),
        .Cin     (Cin),
        .clk     (clk),
        .rst_n   (rst_n),
`ifdef FA2_REG_OUT_EN
        .en      (en),
        .Sum_q   (Sum_q),
        .Carry_q (Carry_q)
`else
        .en      (en)
`endif
    );

    // Clock / watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #90000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // Reference model: plain integer addition.
    function automatic logic [2:0] ref_add(input int a, input int b, input int c);
        int total;
        total = a + b + c;
        return total[2:0];
    endfunction

    task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] a, input logic [1:0] b, input logic c);
        A   = a;
        B   = b;
        Cin = c;
    endtask

    initial begin
        logic [2:0] exp_reg;
        logic [1:0] ra;
        logic [1:0] rb;
        logic       rc;
        logic       ren;

        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        en       = 1'b0;
        drive(2'd0, 2'd0, 1'b0);

        vecs[0] = '{a: 2'd0, b: 2'd3, cin: 1'b0, exp: 3'b011};
        vecs[1] = '{a: 2'd3, b: 2'd0, cin: 1'b1, exp: 3'b100};
        vecs[2] = '{a: 2'd3, b: 2'd3, cin: 1'b1, exp: 3'b111};
        vecs[3] = '{a: 2'd3, b: 2'd2, cin: 1'b1, exp: 3'b110};
        vecs[4] = '{a: 2'd2, b: 2'd2, cin: 1'b1, exp: 3'b101};
        vecs[5] = '{a: 2'd0, b: 2'd1, cin: 1'b0, exp: 3'b001};
        vecs[6] = '{a: 2'd1, b: 2'd0, cin: 1'b1, exp: 3'b010};
        vecs[7] = '{a: 2'd0, b: 2'd0, cin: 1'b0, exp: 3'b000};

        #1;
`ifdef FA2_REG_OUT_EN
        check("reset_state", {Carry_q, Sum_q}, 3'b000);
`endif
        check("comb_during_reset", {Carry, Sum}, 3'b000);

        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].a, vecs[i].b, vecs[i].cin);
            #2;
            check($sformatf("table_%0d", i), {Carry, Sum}, vecs[i].exp);
        end

        for (int v = 0; v < 32; v++) begin
            drive(v[4:3], v[2:1], v[0]);
            #2;
            check($sformatf("sweep_a%0d_b%0d_c%0d", v[4:3], v[2:1], v[0]), {Carry, Sum},
                  ref_add(int'(v[4:3]), int'(v[2:1]), int'(v[0])));
        end

        for (int i = 0; i < 40; i++) begin
            ra = 2'($urandom_range(0, 3));
            rb = 2'($urandom_range(0, 3));
            rc = 1'($urandom_range(0, 1));
            en = 1'($urandom_range(0, 1));
            drive(ra, rb, rc);
            #3;
            check($sformatf("rand_comb_%0d", i), {Carry, Sum}, ref_add(int'(ra), int'(rb), int'(rc)));
        end

`ifdef FA2_REG_OUT_EN
        // Edges during reset with en=1 must not load.
        @(negedge clk);
        rst_n = 1'b0;
        en    = 1'b1;
        drive(2'd3, 2'd3, 1'b1);
        @(posedge clk);
        #1;
        check("no_load_in_reset", {Carry_q, Sum_q}, 3'b000);

        @(negedge clk);
        rst_n = 1'b1;
        en    = 1'b1;
        drive(2'd3, 2'd2, 1'b1);
        @(posedge clk);
        #1;
        check("first_load", {Carry_q, Sum_q}, 3'b110);

        @(negedge clk);
        en = 1'b0;
        drive(2'd1, 2'd1, 1'b0);
        @(posedge clk);
        #1;
        check("hold_q", {Carry_q, Sum_q}, 3'b110);
        check("hold_comb", {Carry, Sum}, 3'b010);

        exp_reg = 3'b110;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            ra  = 2'($urandom_range(0, 3));
            rb  = 2'($urandom_range(0, 3));
            rc  = 1'($urandom_range(0, 1));
            ren = 1'($urandom_range(0, 1));
            en  = ren;
            drive(ra, rb, rc);
            if (ren) exp_reg = ref_add(int'(ra), int'(rb), int'(rc));
            @(posedge clk);
            #1;
            check($sformatf("rand_reg_%0d", i), {Carry_q, Sum_q}, exp_reg);
        end

        @(negedge clk);
        en = 1'b1;
        drive(2'd3, 2'd3, 1'b1);
        @(posedge clk);
        #1;
        check("load_max", {Carry_q, Sum_q}, 3'b111);

        // Mid-cycle async reset: registers clear at once, comb path untouched.
        @(negedge clk);
        en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_clear_q", {Carry_q, Sum_q}, 3'b000);
        check("async_clear_comb", {Carry, Sum}, 3'b111);
        drive(2'd2, 2'd1, 1'b0);
        #1;
        check("comb_tracks_in_reset", {Carry, Sum}, 3'b011);
        check("q_stays_clear", {Carry_q, Sum_q}, 3'b000);

        @(negedge clk);
        rst_n = 1'b1;
        en    = 1'b1;
        @(posedge clk);
        #1;
        check("load_after_release", {Carry_q, Sum_q}, 3'b011);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
